ft600_device_model: RTL and testbench

Synthesizable model of the FT600 chip side of the 245 synchronous FIFO bus, driven from the same `ftdi_clk` as the FPGA-side bridge. It buffers host-to-FPGA words in an RX FIFO and presents them on the bus when the FPGA reads. It captures FPGA-to-host words into a TX FIFO when the FPGA writes. A host-side valid/ready port pair stands in for USB, so the FPGA bridge can be closed-loop tested in simulation or on a second board.

---
 rtl/ft600_device_model.sv | 143 ++++++++++++++
 tb/tb_ft600_device_model.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft600_device_model.sv
// FT600 chip-side model of the 245 synchronous FIFO bus.
// Host-to-FPGA words are queued in an RX FIFO and presented on ftdi_data
// when the FPGA reads; FPGA writes are captured into a TX FIFO that the
// host side drains through a valid/ready port pair.
module ft600_device_model #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                ftdi_clk,
    input  logic                rst_n,
    output logic                ftdi_rxf_n,
    output logic                ftdi_txe_n,
    input  logic                ftdi_oe_n,
    input  logic                ftdi_rd_n,
    input  logic                ftdi_wr_n,
    inout  wire  [15:0]         ftdi_data,
    inout  wire  [1:0]          ftdi_be,
    input  logic [17:0]         host_tx_data,
    input  logic                host_tx_valid,
    output logic                host_tx_ready,
    output logic [17:0]         host_rx_data,
    output logic                host_rx_valid,
    input  logic                host_rx_ready,
    output logic [DEPTH_LOG2:0] rx_count,
    output logic [DEPTH_LOG2:0] tx_count,
    output logic                proto_err
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    // Storage holds data only; it is never reset, occupancy is tracked by counts.
    logic [17:0] rx_mem [DEPTH];
    logic [17:0] tx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_count_next, tx_count_next;

    logic        rx_empty, rx_full, tx_empty;
    logic        rx_push, rx_pop, tx_push, tx_pop;
    logic        bus_drive;
    logic [17:0] bus_word;
    logic        err_now;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);

    assign host_tx_ready = !rx_full;
    assign host_rx_valid = !tx_empty;
    assign host_rx_data  = tx_mem[tx_rd_ptr];

    assign rx_push = host_tx_valid & host_tx_ready;
    assign rx_pop  = !ftdi_oe_n & !ftdi_rd_n & !rx_empty;
    // Capture is gated by the registered flag the FPGA actually sees.
    assign tx_push = !ftdi_wr_n & !ftdi_txe_n;
    assign tx_pop  = host_rx_valid & host_rx_ready;

    // Drive only while OE is asserted and the FPGA is not writing; an empty
    // FIFO presents zeros rather than stale storage. Reset forces high-Z.
    assign bus_drive = rst_n & !ftdi_oe_n & ftdi_wr_n;
    assign bus_word  = rx_empty ? 18'h0 : rx_mem[rx_rd_ptr];
    assign ftdi_data = bus_drive ? bus_word[15:0]  : 16'hzzzz;
    assign ftdi_be   = bus_drive ? bus_word[17:16] : 2'bzz;

    // Any of the four bus protocol violations seen at this edge.
    assign err_now = (!ftdi_oe_n & !ftdi_wr_n)
                   | (!ftdi_rd_n &  ftdi_oe_n)
                   | (!ftdi_rd_n & !ftdi_oe_n & ftdi_rxf_n)
                   | (!ftdi_wr_n &  ftdi_txe_n);

    // Next-state occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        rx_count_next = rx_count;
        tx_count_next = tx_count;
        if (rx_push && !rx_pop) begin
            rx_count_next = rx_count + CNT_ONE;
        end else if (rx_pop && !rx_push) begin
            rx_count_next = rx_count - CNT_ONE;
        end
        if (tx_push && !tx_pop) begin
            tx_count_next = tx_count + CNT_ONE;
        end else if (tx_pop && !tx_push) begin
            tx_count_next = tx_count - CNT_ONE;
        end
    end

    // RX storage write from the host port.
    always_ff @(posedge ftdi_clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= host_tx_data;
        end
    end

    // TX storage write from the bus pins.
    always_ff @(posedge ftdi_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= {ftdi_be, ftdi_data};
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            rx_count <= rx_count_next;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            tx_count <= tx_count_next;
        end
    end

    // Bus status flags registered from next-state counts; sticky error flag.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            ftdi_rxf_n <= 1'b1;
            ftdi_txe_n <= 1'b1;
            proto_err  <= 1'b0;
        end else begin
            ftdi_rxf_n <= (rx_count_next == '0);
            ftdi_txe_n <= (tx_count_next == FULL_CNT);
            if (err_now) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft600_device_model.sv
// Scoreboard bench for ft600_device_model: stimulus queues expected words,
// negedge monitors pop and compare whenever the DUT presents data.
module tb_ft600_device_model;

    localparam int DL2 = 4;

    logic           clk;
    logic           rst_n;
    logic           oe_n, rd_n, wr_n;
    logic           fpga_drive;
    logic [15:0]    fpga_data;
    logic [1:0]     fpga_be;
    wire  [15:0]    ftdi_data;
    wire  [1:0]     ftdi_be;
    logic           rxf_n, txe_n;
    logic [17:0]    host_tx_data;
    logic           host_tx_valid, host_tx_ready;
    logic [17:0]    host_rx_data;
    logic           host_rx_valid, host_rx_ready;
    logic [DL2:0]   rx_count, tx_count;
    logic           proto_err;

    int n_vec = 0;
    int n_err = 0;
    int host_pops = 0;

    logic [17:0] bus_q [$];
    logic [17:0] host_q [$];

    // Weak pull-ups make an undriven bus read as all ones.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu_d
        pullup (ftdi_data[gi]);
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_pu_b
        pullup (ftdi_be[gi]);
    end

    assign ftdi_data = fpga_drive ? fpga_data : 16'hzzzz;
    assign ftdi_be   = fpga_drive ? fpga_be   : 2'bzz;

    ft600_device_model #(.DEPTH_LOG2(DL2)) dut (
        .ftdi_clk      (clk),
        .rst_n         (rst_n),
        .ftdi_rxf_n    (rxf_n),
        .ftdi_txe_n    (txe_n),
        .ftdi_oe_n     (oe_n),
        .ftdi_rd_n     (rd_n),
        .ftdi_wr_n     (wr_n),
        .ftdi_data     (ftdi_data),
        .ftdi_be       (ftdi_be),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .rx_count      (rx_count),
        .tx_count      (tx_count),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: a word is consumed at the next edge while OE and RD are low.
    always @(negedge clk) begin : mon_bus
        logic [17:0] e;
        if (rst_n && !oe_n && !rd_n && wr_n && bus_q.size() > 0) begin
            e = bus_q.pop_front();
            chk("bus_read", {14'h0, ftdi_be, ftdi_data}, {14'h0, e});
        end
    end

    // Host monitor: a word is consumed at the next edge while valid and ready.
    always @(negedge clk) begin : mon_host
        logic [17:0] e;
        if (rst_n && host_rx_valid && host_rx_ready) begin
            host_pops++;
            if (host_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL host_rx_extra: got %0h, expected no word", host_rx_data);
            end else begin
                e = host_q.pop_front();
                chk("host_rx", {14'h0, host_rx_data}, {14'h0, e});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rxf_n"},  rxf_n, 1);
        chk({tag, "_txe_n"},  txe_n, 1);
        chk({tag, "_err"},    proto_err, 0);
        chk({tag, "_rxvld"},  host_rx_valid, 0);
        chk({tag, "_txrdy"},  host_tx_ready, 1);
        chk({tag, "_rxcnt"},  rx_count, 0);
        chk({tag, "_txcnt"},  tx_count, 0);
        chk({tag, "_bus_z"},  {ftdi_be, ftdi_data}, 18'h3FFFF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_q.delete();
        host_q.delete();
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_txe_n", txe_n, 0);
        chk("rel_rxf_n", rxf_n, 1);
    endtask

    task automatic drain(input int expect_pops, input string tag);
        host_pops = 0;
        host_rx_ready = 1'b1;
        for (int c = 0; c < 40 && tx_count != 0; c++) step();
        host_rx_ready = 1'b0;
        chk({tag, "_txcnt"}, tx_count, 0);
        chk({tag, "_pops"}, host_pops, expect_pops);
        chk({tag, "_rxvld"}, host_rx_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] words [8];
        words = '{16'h3130, 16'h3332, 16'h3534, 16'h3736,
                  16'h3938, 16'h6261, 16'h6463, 16'h6665};
        rst_n = 1'b1;
        oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        fpga_drive = 1'b0; fpga_data = '0; fpga_be = '0;
        host_tx_data = '0; host_tx_valid = 1'b0; host_rx_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_txe_n", txe_n, 0);
        chk("first_rxf_n", rxf_n, 1);
        chk("first_bus_z", {ftdi_be, ftdi_data}, 18'h3FFFF);
        chk("first_err", proto_err, 0);

        // Host pushes 8 words, FPGA reads them back.
        for (int i = 0; i < 8; i++) begin
            host_tx_data = {2'b11, words[i]};
            host_tx_valid = 1'b1;
            bus_q.push_back({2'b11, words[i]});
            step();
            if (i == 0) chk("push1_rxf_n", rxf_n, 0);
        end
        host_tx_valid = 1'b0;
        chk("push8_rxcnt", rx_count, 8);
        oe_n = 1'b0;
        step();
        chk("oe_head", {ftdi_be, ftdi_data}, {2'b11, 16'h3130});
        rd_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 6) chk("pop7_rxf_n", rxf_n, 0);
        end
        chk("pop8_rxf_n", rxf_n, 1);
        chk("pop8_rxcnt", rx_count, 0);
        chk("pop8_err", proto_err, 0);
        chk("empty_bus_zero", {ftdi_be, ftdi_data}, 18'h0);
        // Read past empty: flags error, pops nothing.
        step();
        rd_n = 1'b1; oe_n = 1'b1;
        chk("rd_empty_err", proto_err, 1);
        chk("rd_empty_rxcnt", rx_count, 0);
        do_reset();

        // FPGA writes 8 words, host drains.
        fpga_drive = 1'b1; fpga_be = 2'b11; wr_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fpga_data = words[i];
            host_q.push_back({2'b11, words[i]});
            step();
        end
        wr_n = 1'b1; fpga_drive = 1'b0;
        chk("wr8_txcnt", tx_count, 8);
        chk("wr8_rxvld", host_rx_valid, 1);
        drain(8, "drain8");
        chk("wr8_err", proto_err, 0);

        // 17 writes into a 16-deep FIFO: the last is dropped.
        fpga_drive = 1'b1; fpga_be = 2'b01; wr_n = 1'b0;
        for (int i = 0; i < 17; i++) begin
            fpga_data = 16'hA000 + 16'(i);
            if (i < 16) host_q.push_back({2'b01, 16'hA000 + 16'(i)});
            step();
            if (i == 14) chk("wr15_txe_n", txe_n, 0);
            if (i == 15) begin
                chk("wr16_txe_n", txe_n, 1);
                chk("wr16_err", proto_err, 0);
            end
        end
        wr_n = 1'b1; fpga_drive = 1'b0;
        chk("wr17_err", proto_err, 1);
        chk("wr17_txcnt", tx_count, 16);
        drain(16, "drain16");
        do_reset();

        // Simultaneous push and pop across pointer wrap.
        host_tx_data = {2'b10, 16'h5000};
        host_tx_valid = 1'b1;
        bus_q.push_back({2'b10, 16'h5000});
        step();
        host_tx_valid = 1'b0;
        oe_n = 1'b0;
        step();
        for (int i = 1; i <= 20; i++) begin
            host_tx_data = {2'b10, 16'h5000 + 16'(i)};
            host_tx_valid = 1'b1;
            rd_n = 1'b0;
            bus_q.push_back({2'b10, 16'h5000 + 16'(i)});
            step();
            chk("stream_rxcnt", rx_count, 1);
            chk("stream_rxf_n", rxf_n, 0);
        end
        host_tx_valid = 1'b0;
        step();
        rd_n = 1'b1; oe_n = 1'b1;
        chk("stream_end_rxcnt", rx_count, 0);
        chk("stream_end_rxf_n", rxf_n, 1);
        chk("stream_end_err", proto_err, 0);
        chk("stream_q_empty", bus_q.size(), 0);

        // Contention: model must release the bus.
        rd_n = 1'b1; oe_n = 1'b0; wr_n = 1'b0;
        #3;
        chk("contend_bus_z", {ftdi_be, ftdi_data}, 18'h3FFFF);
        step();
        chk("contend_err", proto_err, 1);
        wr_n = 1'b1; oe_n = 1'b1;

        // Asynchronous reset in the middle of a read burst.
        for (int i = 0; i < 3; i++) begin
            host_tx_data = {2'b11, 16'h7000 + 16'(i)};
            host_tx_valid = 1'b1;
            bus_q.push_back({2'b11, 16'h7000 + 16'(i)});
            step();
        end
        host_tx_valid = 1'b0;
        oe_n = 1'b0;
        step();
        rd_n = 1'b0;
        step();
        chk("mid_rxcnt", rx_count, 2);
        #2;
        rst_n = 1'b0;
        bus_q.delete();
        host_q.delete();
        #1;
        check_reset_outputs("async");
        oe_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_txe_n", txe_n, 0);
        chk("post_rxcnt", rx_count, 0);

        step();
        chk("final_bus_q", bus_q.size(), 0);
        chk("final_host_q", host_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
